// File: rtl/fpaa_prog_seq.sv
// fpaa_prog_seq: floating-gate programming sequencer feeding the island programming mux.
// Define FPAA_PROG_PULSE_CNT_EN to add a saturating completed-pulse counter (total_pulses, clr_total).
module fpaa_prog_seq #(
  parameter int ROWS      = 7,
  parameter int COLS      = 7,
  parameter int ROW_W     = 3,
  parameter int COL_W     = 3,
  parameter int CNT_W     = 8,
  parameter int SETUP_CYC = 4,
  parameter int PULSE_CYC = 16,
  parameter int GAP_CYC   = 8
) (
  input  logic             clk,
  input  logic             rst,
`ifdef FPAA_PROG_PULSE_CNT_EN
  input  logic             clr_total,
  output logic [15:0]      total_pulses,
`endif
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [ROW_W-1:0] cmd_row,
  input  logic [COL_W-1:0] cmd_col,
  input  logic [CNT_W-1:0] cmd_pulses,
  input  logic             abort,
  output logic [ROWS-1:0]  row_sel,
  output logic [COLS-1:0]  col_sel,
  output logic             vinj_en,
  output logic             vtun_en,
  output logic             meas_en,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             aborted
);

  localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int MAX_CYC = (MAX_SP > GAP_CYC) ? MAX_SP : GAP_CYC;
  localparam int PH_W    = $clog2(MAX_CYC + 1);

  localparam logic [PH_W-1:0]  SETUP_LD = PH_W'(SETUP_CYC - 1);
  localparam logic [PH_W-1:0]  PULSE_LD = PH_W'(PULSE_CYC - 1);
  localparam logic [PH_W-1:0]  GAP_LD   = PH_W'(GAP_CYC - 1);
  localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] OP_MEAS  = 2'b00;
  localparam logic [1:0] OP_INJ   = 2'b01;
  localparam logic [1:0] OP_ERASE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_GAP, S_MEAS, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic             err_d, aborted_d;
  logic             range_bad;

  logic [ROWS-1:0]  row_sel_d;
  logic [COLS-1:0]  col_sel_d;
  logic             vinj_d, vtun_d, meas_d, busy_d, done_d, ready_d;

  // Erase addresses the whole island, so its row/col are never range-checked.
  assign range_bad = (cmd_op != OP_ERASE) &&
                     ((int'(cmd_row) >= ROWS) || (int'(cmd_col) >= COLS));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    rem_d     = rem_q;
    op_d      = op_q;
    row_d     = row_q;
    col_d     = col_q;
    err_d     = 1'b0;
    aborted_d = 1'b0;
    if (abort && (state_q inside {S_SETUP, S_PULSE, S_GAP, S_MEAS})) begin
      state_d   = S_DONE;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            if (range_bad) begin
              err_d = 1'b1;
            end else begin
              op_d    = cmd_op;
              row_d   = cmd_row;
              col_d   = cmd_col;
              rem_d   = cmd_pulses;
              ph_d    = SETUP_LD;
              state_d = S_SETUP;
            end
          end
        end
        S_SETUP: begin
          if (ph_q != '0) begin
            ph_d = ph_q - PH_ONE;
          end else if (op_q == OP_MEAS) begin
            ph_d    = PULSE_LD;
            state_d = S_MEAS;
          end else if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            ph_d    = PULSE_LD;
            state_d = S_PULSE;
          end
        end
        S_PULSE: begin
          if (ph_q != '0) begin
            ph_d = ph_q - PH_ONE;
          end else begin
            rem_d = rem_q - CNT_ONE;
            if (rem_q > CNT_ONE) begin
              ph_d    = GAP_LD;
              state_d = S_GAP;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_GAP: begin
          if (ph_q != '0) begin
            ph_d = ph_q - PH_ONE;
          end else begin
            ph_d    = PULSE_LD;
            state_d = S_PULSE;
          end
        end
        S_MEAS: begin
          if (ph_q != '0) begin
            ph_d = ph_q - PH_ONE;
          end else begin
            state_d = S_DONE;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Output decode from the next state, so every output leaves a flop
  always_comb begin
    row_sel_d = '0;
    col_sel_d = '0;
    vinj_d    = 1'b0;
    vtun_d    = 1'b0;
    meas_d    = 1'b0;
    busy_d    = (state_d != S_IDLE);
    ready_d   = (state_d == S_IDLE);
    done_d    = (state_d == S_DONE);
    if (state_d != S_IDLE) begin
      if (op_d == OP_ERASE) begin
        row_sel_d = '1;
        col_sel_d = '1;
      end else begin
        for (int i = 0; i < ROWS; i++) row_sel_d[i] = (int'(row_d) == i);
        for (int j = 0; j < COLS; j++) col_sel_d[j] = (int'(col_d) == j);
      end
    end
    case (state_d)
      S_PULSE: begin
        if (op_d == OP_INJ) vinj_d = 1'b1;
        else                vtun_d = 1'b1;
      end
      S_MEAS:  meas_d = 1'b1;
      default: ;
    endcase
  end

  // Output register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_ready <= 1'b1;
      row_sel   <= '0;
      col_sel   <= '0;
      vinj_en   <= 1'b0;
      vtun_en   <= 1'b0;
      meas_en   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      cmd_ready <= ready_d;
      row_sel   <= row_sel_d;
      col_sel   <= col_sel_d;
      vinj_en   <= vinj_d;
      vtun_en   <= vtun_d;
      meas_en   <= meas_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
      aborted   <= aborted_d;
    end
  end

`ifdef FPAA_PROG_PULSE_CNT_EN
  logic pulse_end;

  // A pulse counts only if its final cycle is not cut short by abort.
  assign pulse_end = (state_q == S_PULSE) && (ph_q == '0) && !abort;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      total_pulses <= '0;
    end else if (clr_total) begin
      total_pulses <= '0;
    end else if (pulse_end && (total_pulses != 16'hFFFF)) begin
      total_pulses <= total_pulses + 16'd1;
    end
  end
`endif

endmodule

// File: doc/fpaa_prog_seq.md
Name: fpaa_prog_seq

Overview:
- Programming sequencer directly upstream of the fabric's programming mux.
- Accepts one floating-gate programming command at a time over a valid/ready handshake.
- Decodes the target row/column of the island switch matrix into one-hot select lines.
- Produces timed setup, inject/tunnel/measure pulse trains for the mux to route to the addressed CAB switch.

Parameters:
- ROWS, 7, number of switch-matrix rows (row_sel width)
- COLS, 7, number of CAB columns in the island (col_sel width)
- ROW_W, 3, width of cmd_row
- COL_W, 3, width of cmd_col
- CNT_W, 8, width of cmd_pulses
- SETUP_CYC, 4, cycles selects are held before the first pulse (>=1)
- PULSE_CYC, 16, cycles per pulse / measure window (>=1)
- GAP_CYC, 8, low cycles between consecutive pulses (>=1)

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  00 measure, 01 inject, 10 tunnel, 11 global erase
- cmd_row  in  ROW_W  target row
- cmd_col  in  COL_W  target column
- cmd_pulses  in  CNT_W  pulse count (inject/tunnel/erase)
- abort  in  1  terminate current command
- row_sel  out  ROWS  one-hot row select to programming mux
- col_sel  out  COLS  one-hot column select to programming mux
- vinj_en  out  1  injection pulse enable
- vtun_en  out  1  tunnelling pulse enable
- meas_en  out  1  measurement window enable
- busy  out  1  command in progress
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle range-error pulse
- aborted  out  1  one-cycle pulse, qualifies done on abort

Behaviour:
- Reset (async, immediate): state IDLE; cmd_ready=1; all other outputs 0; latched command cleared.
- All outputs are registered; no combinational input-to-output path.
- States: IDLE, SETUP, PULSE, GAP, MEAS, DONE.
- IDLE: cmd_ready=1 only here. Accept on cmd_valid&&cmd_ready; latch op/row/col/pulses.
- Range check: op!=11 with cmd_row>=ROWS or cmd_col>=COLS -> command consumed; err=1 next cycle; stay IDLE; selects stay 0.
- Select decode: op 11 drives row_sel/col_sel all ones and ignores row/col. Otherwise selects are one-hot of row/col.
- Selects are valid from the cycle after accept through DONE inclusive; 0 in IDLE.
- SETUP: SETUP_CYC cycles, all enables 0. Exit order:
  - op 00 -> MEAS
  - pulses==0 -> DONE
  - otherwise -> PULSE
- PULSE: PULSE_CYC cycles.
  - vinj_en=1 for op 01; vtun_en=1 for op 10/11.
  - Remaining count decremented at pulse end.
  - Remaining >0 -> GAP; else -> DONE.
- GAP: GAP_CYC cycles, enables 0, then PULSE.
- MEAS: meas_en=1 for PULSE_CYC cycles, then DONE. cmd_pulses is ignored.
- DONE: one cycle; enables 0; done=1; then IDLE, with cmd_ready=1 the following cycle.
- busy=1 in every state except IDLE.
- vinj_en, vtun_en and meas_en are mutually exclusive and never high outside PULSE/MEAS.
- abort (sampled in any non-IDLE state):
  - Next cycle: all enables 0, state DONE, done=1 and aborted=1.
  - Ignored in IDLE and DONE.
  - abort and cmd_valid together in IDLE: command accepted normally.
- Counters are saturation-free down-counters. PULSE_CYC/GAP_CYC/SETUP_CYC counters are sized $clog2(max+1).
- cmd_pulses=255 must run 255 pulses (no wrap).

Optional Feature:
- Macro FPAA_PROG_PULSE_CNT_EN.
- When defined:
  - Adds output total_pulses (16 bits) plus input clr_total (1 bit).
  - total_pulses increments on each completed PULSE phase and saturates at 16'hFFFF.
  - A PULSE phase cut short by abort does not count.
  - clr_total zeroes it synchronously; clr_total wins over a simultaneous increment.
  - Reset clears it.
- When not defined: neither port exists; no counter logic.

Test Plan:
- Inject, row 2, col 5, pulses 3, accepted at cycle T:
  - row_sel=7'b0000100, col_sel=7'b0100000 from T+1.
  - vinj_en high T+5..T+20, T+29..T+44, T+53..T+68.
  - done at T+69; cmd_ready high at T+70.
- Measure, row 0, col 0, pulses 9: meas_en high T+5..T+20; vinj_en/vtun_en never high; done at T+21.
- Range error, row 7, col 1, op 01: err pulse at T+1; selects stay 0; busy stays 0; cmd_ready stays 1.
- Global erase, pulses 1: row_sel=7'h7F, col_sel=7'h7F; vtun_en high T+5..T+20; done at T+21.
- Tunnel, pulses 2, abort asserted at T+10 (mid first pulse):
  - vtun_en low at T+11; done=aborted=1 at T+11; IDLE at T+12.
  - With FPAA_PROG_PULSE_CNT_EN, total_pulses is unchanged.
- Async reset asserted mid-PULSE between clock edges:
  - vinj_en/row_sel/col_sel drop to 0 immediately.
  - cmd_ready=1 after release; next command runs normally.
